// File: rtl/ls_pkg.sv
// Shared types, mode encodings and saturating arithmetic helpers for the
// zoned life-support controller.
package ls_pkg;

    typedef enum logic [1:0] {
        NOMINAL = 2'd0,
        WARN    = 2'd1,
        CRIT    = 2'd2,
        FATAL   = 2'd3
    } alarm_t;

    localparam logic [3:0] MODE_STEALTH = 4'b1000;
    localparam logic [3:0] MODE_DEFENCE = 4'b0100;

    // Adds with one guard bit, then clamps to max.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max}) ? max : sum[31:0];
    endfunction

    // Subtracts, clamping at zero instead of wrapping.
    function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                            input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

endpackage

// File: rtl/ls_zone_alarm.sv
// Per-compartment alarm state machine with a debounce counter guarding the
// WARN->CRIT transition. Inputs are the zone's registered o2/temp values.
module ls_zone_alarm
    import ls_pkg::*;
#(
    parameter int W          = 16,
    parameter int O2_WARN    = 300,
    parameter int O2_CRIT    = 100,
    parameter int TEMP_WARN  = 40,
    parameter int TEMP_CRIT  = 60,
    parameter int TEMP_FATAL = 100,
    parameter int DEBOUNCE   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] o2_i,
    input  logic [W-1:0] temp_i,
    output logic [1:0]   alarm_o
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    alarm_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          warn, crit, die;

    // Threshold conditions on the registered zone values.
    always_comb begin
        warn = (o2_i < W'(O2_WARN)) || (temp_i > W'(TEMP_WARN));
        crit = (o2_i < W'(O2_CRIT)) || (temp_i > W'(TEMP_CRIT));
        die  = (o2_i == '0)         || (temp_i >= W'(TEMP_FATAL));
    end

    // Next state: load clears everything, death wins next, FATAL is sticky.
    // The counter defaults to zero so any non-counting cycle clears it.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        if (load_i) begin
            state_d = NOMINAL;
        end else if (die || (state_q == FATAL)) begin
            state_d = FATAL;
        end else begin
            case (state_q)
                NOMINAL: begin
                    if (warn) state_d = WARN;
                end
                WARN: begin
                    if (!warn) begin
                        state_d = NOMINAL;
                    end else if (crit) begin
                        if (cnt_q == CW'(DEBOUNCE - 1)) state_d = CRIT;
                        else                            cnt_d = cnt_q + 1'b1;
                    end
                end
                CRIT: begin
                    if (!crit) state_d = WARN;
                end
                default: state_d = FATAL;
            endcase
        end
    end

    // State and debounce counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= NOMINAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign alarm_o = state_q;

endmodule

// File: rtl/life_support_zoned.sv
// Multi-compartment life-support controller: per-zone o2/temp tracking, a
// shared power reserve, rationed o2 resupply and per-zone alarm FSMs.
// Build option LS_PRIORITY_SUP_EN: supply goes to the zone with the lowest o2
// (ties to the lowest index) instead of round-robin; the pointer is held at 0.
module life_support_zoned
    import ls_pkg::*;
#(
    parameter int N_ZONES     = 4,
    parameter int W           = 16,
    parameter int O2_MAX      = 1000,
    parameter int PWR_MAX     = 1000,
    parameter int TEMP_NOM    = 20,
    parameter int TEMP_WARN   = 40,
    parameter int TEMP_CRIT   = 60,
    parameter int TEMP_FATAL  = 100,
    parameter int O2_WARN     = 300,
    parameter int O2_CRIT     = 100,
    parameter int SUP_RATE    = 8,
    parameter int BREACH_LOSS = 5,
    parameter int DEBOUNCE    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic [N_ZONES*W-1:0]          load_o2,
    input  logic [N_ZONES*W-1:0]          load_temp,
    input  logic [W-1:0]                  load_pwr,
    input  logic                          chrg,
    input  logic                          o2sup,
    input  logic [3:0]                    mode,
    input  logic [N_ZONES-1:0]            breach,
    output logic [N_ZONES*W-1:0]          zone_o2,
    output logic [N_ZONES*W-1:0]          zone_temp,
    output logic [W-1:0]                  power,
    output logic [N_ZONES*2-1:0]          zone_alarm,
    output logic [$clog2(N_ZONES)-1:0]    sup_zone,
    output logic                          sup_gnt,
    output logic                          fatal
);

    localparam int          ZW       = $clog2(N_ZONES);
    localparam logic [31:0] TEMP_SAT = 32'((64'd1 << W) - 64'd1);

    logic [W-1:0]       power_q, power_d;
    logic [ZW-1:0]      ptr_q, ptr_d;
    logic               fatal_q, fatal_d;
    logic [N_ZONES-1:0] zone_fatal;
    logic               is_stealth, is_defence, pwr_ok;

    assign is_stealth = (mode == MODE_STEALTH);
    assign is_defence = (mode == MODE_DEFENCE);
    assign pwr_ok     = (power_q != '0);
    assign sup_gnt    = o2sup && pwr_ok && !is_stealth;

`ifdef LS_PRIORITY_SUP_EN
    logic [W-1:0]  best_o2;
    logic [ZW-1:0] best_idx;

    // Lowest-o2 zone; strict compare keeps the lowest index on ties.
    always_comb begin
        best_o2  = zone_o2[W-1:0];
        best_idx = '0;
        for (int i = 1; i < N_ZONES; i++) begin
            if (zone_o2[i*W +: W] < best_o2) begin
                best_o2  = zone_o2[i*W +: W];
                best_idx = ZW'(i);
            end
        end
    end

    assign sup_zone = best_idx;
    assign ptr_d    = '0;
`else
    assign sup_zone = ptr_q;

    // Round-robin pointer moves only when a grant actually happens.
    always_comb begin
        ptr_d = ptr_q;
        if (!load && sup_gnt) begin
            ptr_d = (ptr_q == ZW'(N_ZONES - 1)) ? '0 : ptr_q + 1'b1;
        end
    end
`endif

    // Power: charging beats every drain; grant or defence drains one unit.
    always_comb begin
        power_d = power_q;
        if (load) begin
            power_d = load_pwr;
        end else if (chrg) begin
            power_d = W'(sat_add(32'(power_q), 32'd1, 32'(PWR_MAX)));
        end else if (sup_gnt || is_defence) begin
            power_d = W'(sat_sub(32'(power_q), 32'd1));
        end
    end

    assign fatal_d = load ? 1'b0 : (|zone_fatal);

    // Shared registers: power, supply pointer, fatal summary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            power_q <= W'(PWR_MAX);
            ptr_q   <= '0;
            fatal_q <= 1'b0;
        end else begin
            power_q <= power_d;
            ptr_q   <= ptr_d;
            fatal_q <= fatal_d;
        end
    end

    assign power = power_q;
    assign fatal = fatal_q;

    for (genvar gi = 0; gi < N_ZONES; gi++) begin : g_zone
        logic [W-1:0] o2_q, o2_d, temp_q, temp_d;
        logic         granted;

        assign granted = sup_gnt && (sup_zone == ZW'(gi));

        // o2: granted zone is topped up, every other zone leaks.
        always_comb begin
            o2_d = o2_q;
            if (load) begin
                o2_d = load_o2[gi*W +: W];
            end else if (granted) begin
                o2_d = W'(sat_add(32'(o2_q), 32'(SUP_RATE), 32'(O2_MAX)));
            end else begin
                o2_d = W'(sat_sub(32'(o2_q),
                                  breach[gi] ? 32'(BREACH_LOSS) : 32'd1));
            end
        end

        // Temp: climate control only in NORMAL with power, else heat up.
        always_comb begin
            temp_d = temp_q;
            if (load) begin
                temp_d = load_temp[gi*W +: W];
            end else if (!is_stealth && !is_defence && pwr_ok) begin
                if (temp_q > W'(TEMP_NOM))      temp_d = temp_q - 1'b1;
                else if (temp_q < W'(TEMP_NOM)) temp_d = temp_q + 1'b1;
            end else begin
                temp_d = W'(sat_add(32'(temp_q), 32'd1, TEMP_SAT));
            end
        end

        // Zone value registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                o2_q   <= W'(O2_MAX);
                temp_q <= W'(TEMP_NOM);
            end else begin
                o2_q   <= o2_d;
                temp_q <= temp_d;
            end
        end

        assign zone_o2[gi*W +: W]   = o2_q;
        assign zone_temp[gi*W +: W] = temp_q;

        ls_zone_alarm #(
            .W          (W),
            .O2_WARN    (O2_WARN),
            .O2_CRIT    (O2_CRIT),
            .TEMP_WARN  (TEMP_WARN),
            .TEMP_CRIT  (TEMP_CRIT),
            .TEMP_FATAL (TEMP_FATAL),
            .DEBOUNCE   (DEBOUNCE)
        ) u_alarm (
            .clk     (clk),
            .rst     (rst),
            .load_i  (load),
            .o2_i    (o2_q),
            .temp_i  (temp_q),
            .alarm_o (zone_alarm[gi*2 +: 2])
        );

        assign zone_fatal[gi] = (zone_alarm[gi*2 +: 2] == FATAL);
    end

endmodule

// File: tb/tb_life_support_zoned.sv
// Directed bench for life_support_zoned (4 zones, 16-bit values).
module tb_life_support_zoned;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [63:0] load_o2 = '0;
    logic [63:0] load_temp = '0;
    logic [15:0] load_pwr = '0;
    logic        chrg = 1'b0;
    logic        o2sup = 1'b0;
    logic [3:0]  mode = 4'b0000;
    logic [3:0]  breach = 4'b0000;
    logic [63:0] zone_o2;
    logic [63:0] zone_temp;
    logic [15:0] power;
    logic [7:0]  zone_alarm;
    logic [1:0]  sup_zone;
    logic        sup_gnt;
    logic        fatal;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [3:0] STEALTH = 4'b1000;
    localparam logic [3:0] DEFENCE = 4'b0100;

    life_support_zoned dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_o2    (load_o2),
        .load_temp  (load_temp),
        .load_pwr   (load_pwr),
        .chrg       (chrg),
        .o2sup      (o2sup),
        .mode       (mode),
        .breach     (breach),
        .zone_o2    (zone_o2),
        .zone_temp  (zone_temp),
        .power      (power),
        .zone_alarm (zone_alarm),
        .sup_zone   (sup_zone),
        .sup_gnt    (sup_gnt),
        .fatal      (fatal)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] p4(input logic [15:0] z0, input logic [15:0] z1,
                                       input logic [15:0] z2, input logic [15:0] z3);
        return {z3, z2, z1, z0};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 'h%0h required 'h%0h", tag, obs, exp);
        end
        $display("check %-14s observed 'h%0h required 'h%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; load = 1'b0; chrg = 1'b0; o2sup = 1'b0; mode = 4'b0000; breach = '0;
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic do_load(input logic [63:0] o2v, input logic [63:0] tv, input logic [15:0] pv);
        load = 1'b1; load_o2 = o2v; load_temp = tv; load_pwr = pv;
        step();
        load = 1'b0;
    endtask

    initial begin
        // 1: reset values
        do_reset();
        check("rst_o2",    zone_o2,             p4(1000, 1000, 1000, 1000));
        check("rst_temp",  zone_temp,           p4(20, 20, 20, 20));
        check("rst_power", 64'(power),          64'd1000);
        check("rst_alarm", 64'(zone_alarm),     64'h0);
        check("rst_fatal", 64'(fatal),          64'd0);

`ifndef LS_PRIORITY_SUP_EN
        // 2: round-robin supply over 8 cycles
        o2sup = 1'b1; mode = 4'b0000;
        #1;
        for (int k = 0; k < 8; k++) begin
            check("rr_gnt",  64'(sup_gnt),  64'd1);
            check("rr_zone", 64'(sup_zone), 64'(k % 4));
            step();
        end
        o2sup = 1'b0;
        check("rr_o2",    zone_o2,    p4(997, 998, 999, 1000));
        check("rr_power", 64'(power), 64'd992);
        check("rr_temp",  zone_temp,  p4(20, 20, 20, 20));
`else
        // 6: lowest-o2 supply selection
        do_load(p4(500, 200, 200, 900), p4(20, 20, 20, 20), 16'd1000);
        o2sup = 1'b1;
        #1;
        check("pri_zone0", 64'(sup_zone), 64'd1);
        step();
        check("pri_zone1", 64'(sup_zone), 64'd2);
        o2sup = 1'b0;
`endif

        // 3: zone1 low o2 walks WARN -> CRIT -> FATAL
        do_reset();
        do_load(p4(1000, 50, 1000, 1000), p4(20, 20, 20, 20), 16'd1000);
        check("z1_load_o2", zone_o2, p4(1000, 50, 1000, 1000));
        step();
        check("z1_warn", 64'(zone_alarm), 64'h04);
        repeat (3) step();
        check("z1_debounce", 64'(zone_alarm), 64'h04);
        step();
        check("z1_crit", 64'(zone_alarm), 64'h08);
        repeat (45) step();
        check("z1_o2_zero", zone_o2, p4(950, 0, 950, 950));
        check("z1_pre_fatal", 64'(zone_alarm), 64'h08);
        step();
        check("z1_fatal_st", 64'(zone_alarm), 64'h0C);
        check("fatal_lag",   64'(fatal),      64'd0);
        step();
        check("fatal_rise",  64'(fatal),      64'd1);
        check("o2_sat0",     zone_o2,         p4(948, 0, 948, 948));
        step();
        check("fatal_sticky", 64'(zone_alarm), 64'h0C);
        do_load(p4(1000, 1000, 1000, 1000), p4(20, 20, 20, 20), 16'd1000);
        check("load_clr_al", 64'(zone_alarm), 64'h0);
        check("load_clr_f",  64'(fatal),      64'd0);

        // 4: stealth blocks supply, heats up; no power blocks supply
        do_reset();
        mode = STEALTH; o2sup = 1'b1;
        #1;
        check("stealth_gnt", 64'(sup_gnt), 64'd0);
        repeat (3) step();
        check("stealth_temp", zone_temp,  p4(23, 23, 23, 23));
        check("stealth_pwr",  64'(power), 64'd1000);
        check("stealth_o2",   zone_o2,    p4(997, 997, 997, 997));
        mode = 4'b0000; o2sup = 1'b0;
        do_load(p4(1000, 1000, 1000, 1000), p4(20, 20, 20, 20), 16'd0);
        check("pwr0_load", 64'(power), 64'd0);
        o2sup = 1'b1;
        #1;
        check("pwr0_gnt", 64'(sup_gnt), 64'd0);
        repeat (2) step();
        check("pwr0_temp", zone_temp,  p4(22, 22, 22, 22));
        check("pwr0_hold", 64'(power), 64'd0);
        mode = DEFENCE;
        step();
        check("def_pwr_floor", 64'(power), 64'd0);
        check("def_temp",      zone_temp,  p4(23, 23, 23, 23));
        chrg = 1'b1;
        step();
        check("chrg_pwr",  64'(power), 64'd1);
        check("chrg_temp", zone_temp,  p4(24, 24, 24, 24));
        mode = 4'b0000;
        #1;
        check("chrg_gnt", 64'(sup_gnt), 64'd1);
`ifndef LS_PRIORITY_SUP_EN
        check("chrg_zone", 64'(sup_zone), 64'd0);
`endif
        step();
        check("chrg_gnt_pwr", 64'(power), 64'd2);
        check("cool_temp",    zone_temp,  p4(23, 23, 23, 23));
`ifndef LS_PRIORITY_SUP_EN
        check("sup_sat_o2",   zone_o2,    p4(1000, 995, 995, 995));
`endif
        chrg = 1'b0; o2sup = 1'b0;

        // breach: zone3 loses 5/cycle and clamps at 0
        do_load(p4(500, 500, 500, 7), p4(20, 20, 20, 20), 16'd1000);
        breach = 4'b1000;
        repeat (2) step();
        check("breach_o2", zone_o2, p4(498, 498, 498, 0));
        breach = 4'b0000;

        // 5: temp bouncing across the crit threshold stays in WARN
        do_reset();
        do_load(p4(1000, 1000, 1000, 1000), p4(60, 60, 60, 60), 16'd1000);
        for (int k = 1; k <= 8; k++) begin
            mode = (k % 2 == 1) ? STEALTH : 4'b0000;
            step();
            check("bounce_warn", 64'(zone_alarm), 64'h55);
        end
        mode = STEALTH;
        repeat (4) step();
        check("hold_warn", 64'(zone_alarm), 64'h55);
        step();
        check("hold_crit", 64'(zone_alarm), 64'hAA);
        check("hold_temp", zone_temp,       p4(65, 65, 65, 65));
        mode = 4'b0000;
        repeat (5) step();
        check("cool_crit", 64'(zone_alarm), 64'hAA);
        step();
        check("crit_warn", 64'(zone_alarm), 64'h55);
        check("cool_temp2", zone_temp,      p4(59, 59, 59, 59));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
